apb_master_bridge: RTL and testbench

- APB requester (initiator) that turns a simple command/response interface into APB3 transfers toward APB slaves on the peripheral bus.
- Runs the IDLE/SETUP/ACCESS protocol and inserts wait states until the slave asserts pready.
- Returns read data and slave error status, and aborts with a timeout error if the slave stalls too long.
- Sits between the system-side register/command logic and the APB slave memory blocks.

---
 rtl/apb_master_bridge.sv | 150 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB3 requester: converts a single-command request/response handshake into
// SETUP/ACCESS transfers, with wait-state support and an optional stall timeout.
module apb_master_bridge #(
   parameter int unsigned ADDR_WIDTH     = 5,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   // command side
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   // response side
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   // APB side
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic                  pready,
   input  logic                  pslverr,
   input  logic [DATA_WIDTH-1:0] prdata
);

   // $clog2(1) is 0, so a disabled timeout still gets a 1-bit counter
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CntW-1:0] CntLast =
      (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;
   localparam bit TimeoutEn = (TIMEOUT_CYCLES > 0);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e                state_q, state_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic [CntW-1:0]       cnt_q, cnt_d;

   // Next-state and registered-output computation; everything holds by default
   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      cnt_d         = cnt_q;
      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               state_d  = StSetup;
               psel_d   = 1'b1;
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
            end
         end
         StSetup: begin
            state_d   = StAccess;
            penable_d = 1'b1;
            cnt_d     = '0;
         end
         StAccess: begin
            if (pready) begin
               // completion takes priority over a coincident timeout
               state_d       = StIdle;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = pslverr;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = (!pwrite_q && !pslverr) ? prdata : '0;
            end else if (TimeoutEn && (cnt_q == CntLast)) begin
               state_d       = StIdle;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_rdata_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d   = StIdle;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= StIdle;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         cnt_q         <= cnt_d;
      end
   end

   assign cmd_ready   = (state_q == StIdle);
   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed commands, a small APB slave model and a
// response scoreboard checked by an independent monitor.
module tb_apb_master_bridge;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [4:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [4:0]  paddr;
   logic [31:0] pwdata, prdata;

   apb_master_bridge #(
      .ADDR_WIDTH     (5),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .pready      (pready),
      .pslverr     (pslverr),
      .prdata      (prdata)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int last_acc = 0;

   // Cycle counter used for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic bound_fail(input string name);
      n_chk++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // Slave model: sl_wait pready-low cycles per access, or never ready
   int          sl_wait  = 0;
   logic        sl_err   = 1'b0;
   logic        sl_never = 1'b0;
   logic [4:0]  acc_cnt;
   logic [31:0] mem [32];
   int          run = 0;
   int          acc_len = 0;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) acc_cnt <= '0;
      else if (psel && penable && !pready) acc_cnt <= acc_cnt + 5'd1;
      else acc_cnt <= '0;
   end

   always_comb begin
      pready  = psel && penable && !sl_never && (int'(acc_cnt) == sl_wait);
      // junk on prdata/pslverr while not ready must be ignored by the DUT
      prdata  = pready ? mem[paddr] : 32'hBAD0BAD0;
      pslverr = pready ? sl_err : 1'b1;
   end

   always @(posedge clk) begin
      if (pready && pwrite && !sl_err) mem[paddr] <= pwdata;
   end

   // Length of the most recent ACCESS phase
   always @(posedge clk) begin
      if (psel && penable) run <= run + 1;
      else if (run != 0) begin
         acc_len <= run;
         run     <= 0;
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        to;
      int          acc;
      int          lat;
   } exp_t;
   exp_t sb[$];

   // Monitor: every response pops one expectation
   always @(negedge clk) begin
      if (resetn && rsp_valid) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_rsp: rsp_valid=1 with no command pending");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
            chk("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
         end
      end
   end

   // Present a command (called at a negedge) and push its expected response
   task automatic send(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input logic et,
                       input int lat);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         bound_fail("cmd_accept");
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      last_acc = cyc;
      sb.push_back('{rdata: er, err: ee, to: et, acc: cyc, lat: lat});
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         bound_fail("rsp_drain");
         sb.delete();
      end
      @(negedge clk);
   endtask

   int a0;

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      mem[5'h1F] = 32'hDEADBEEF;
      resetn    = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      #12;
      chk("rst_psel", 32'(psel), 32'd0);
      chk("rst_penable", 32'(penable), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_paddr", 32'(paddr), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // Write 0x12345678 to 0x03, zero wait states, phase-by-phase checks
      send(1'b1, 5'h03, 32'h12345678, 32'h0, 1'b0, 1'b0, 3);
      cmd_valid = 1'b0;
      chk("w_c1_psel", 32'(psel), 32'd1);
      chk("w_c1_penable", 32'(penable), 32'd0);
      chk("w_c1_paddr", 32'(paddr), 32'h03);
      chk("w_c1_pwdata", pwdata, 32'h12345678);
      chk("w_c1_pwrite", 32'(pwrite), 32'd1);
      chk("w_c1_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      chk("w_c2_psel", 32'(psel), 32'd1);
      chk("w_c2_penable", 32'(penable), 32'd1);
      chk("w_c2_paddr", 32'(paddr), 32'h03);
      chk("w_c2_pwdata", pwdata, 32'h12345678);
      @(negedge clk);
      chk("w_c3_psel", 32'(psel), 32'd0);
      chk("w_c3_penable", 32'(penable), 32'd0);
      chk("w_c3_cmd_ready", 32'(cmd_ready), 32'd1);
      drain();

      // Read 0x1F with two wait states
      sl_wait = 2;
      send(1'b0, 5'h1F, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 5);
      cmd_valid = 1'b0;
      drain();
      chk("rd_wait_access_len", 32'(acc_len), 32'd3);
      chk("rd_rdata_hold", rsp_rdata, 32'hDEADBEEF);
      chk("rd_valid_pulse", 32'(rsp_valid), 32'd0);
      sl_wait = 0;

      // Read 0x05 with slave error
      sl_err = 1'b1;
      send(1'b0, 5'h05, 32'h0, 32'h0, 1'b1, 1'b0, 3);
      cmd_valid = 1'b0;
      drain();
      sl_err = 1'b0;

      // Slave never ready: timeout after 16 ACCESS cycles
      sl_never = 1'b1;
      send(1'b0, 5'h1F, 32'h0, 32'h0, 1'b1, 1'b1, 18);
      cmd_valid = 1'b0;
      drain();
      chk("to_access_len", 32'(acc_len), 32'd16);
      chk("to_err_hold", 32'(rsp_err), 32'd1);
      sl_never = 1'b0;

      // Ready on the 16th ACCESS cycle: completion beats timeout
      sl_wait = 15;
      send(1'b0, 5'h1F, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 18);
      cmd_valid = 1'b0;
      drain();
      chk("edge_access_len", 32'(acc_len), 32'd16);
      sl_wait = 0;

      // Back-to-back with cmd_valid held high
      send(1'b1, 5'h01, 32'hA5A50001, 32'h0, 1'b0, 1'b0, 3);
      a0 = last_acc;
      send(1'b0, 5'h01, 32'h0, 32'hA5A50001, 1'b0, 1'b0, 3);
      chk("b2b_gap1", 32'(last_acc - a0), 32'd3);
      a0 = last_acc;
      send(1'b1, 5'h02, 32'h0000BEEF, 32'h0, 1'b0, 1'b0, 3);
      chk("b2b_gap2", 32'(last_acc - a0), 32'd3);
      cmd_valid = 1'b0;
      drain();

      // Reset asserted mid-ACCESS drops the transfer
      sl_never = 1'b1;
      send(1'b0, 5'h03, 32'h0, 32'h0, 1'b0, 1'b0, 3);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_penable", 32'(penable), 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_psel", 32'(psel), 32'd0);
      chk("mid_rst_penable", 32'(penable), 32'd0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      void'(sb.pop_back());
      @(negedge clk);
      resetn   = 1'b1;
      sl_never = 1'b0;
      @(negedge clk);
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst_psel", 32'(psel), 32'd0);

      // Bridge still works after reset
      send(1'b0, 5'h1F, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 3);
      cmd_valid = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
